// File: rtl/ldl_rr_pend_age_if.sv
// Request/grant bundle between the pending-age feeder and its neighbours.
// The master side pushes requests and returns the arbiter grant.
// The slave side is the feeder itself.
interface ldl_rr_pend_age_if #(
  parameter int REQ_WIDTH = 8,
  parameter int COS_WIDTH = 2
);
  logic [REQ_WIDTH-1:0]                push;
  logic [REQ_WIDTH-1:0][COS_WIDTH-1:0] push_cos;
  logic [REQ_WIDTH-1:0]                full;
  logic [REQ_WIDTH-1:0]                req;
  logic [REQ_WIDTH-1:0][COS_WIDTH-1:0] cos;
  logic [REQ_WIDTH-1:0]                grant_hot;
  logic                                grant_valid;
  logic                                grant_ready;
  logic                                err;

  modport master (
    output push, push_cos, grant_hot, grant_valid, grant_ready,
    input  full, req, cos, err
  );

  modport slave (
    input  push, push_cos, grant_hot, grant_valid, grant_ready,
    output full, req, cos, err
  );
endinterface

// File: rtl/ldl_rr_pend_age.sv
// Pending-request feeder for the priority round-robin arbiter.
// Each requester has a pending counter, a burst base cos and an aging boost.
// A requester that keeps losing accepted grants gets its cos raised step by step.
// Optional protocol checker: define LDL_RR_PEND_CHK_EN to enable the sticky err flag.
module ldl_rr_pend_age #(
  parameter int BIN_WIDTH = 3,
  parameter int COS_WIDTH = 2,
  parameter int REQ_WIDTH = 1 << BIN_WIDTH,
  parameter int CNT_WIDTH = 4,
  parameter int AGE_WIDTH = 4,
  parameter int AGE_LIMIT = 8
) (
  input logic             clk,
  input logic             rst,
  ldl_rr_pend_age_if.slave bus
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [COS_WIDTH-1:0] COS_MAX = {COS_WIDTH{1'b1}};
  localparam logic [COS_WIDTH-1:0] COS_ONE = COS_WIDTH'(1);
  localparam logic [AGE_WIDTH-1:0] AGE_TOP = AGE_WIDTH'(AGE_LIMIT - 1);
  localparam logic [AGE_WIDTH-1:0] AGE_ONE = AGE_WIDTH'(1);

  logic                                take;
  logic [REQ_WIDTH-1:0]                full_vec;
  logic [REQ_WIDTH-1:0]                req_vec;
  logic [REQ_WIDTH-1:0][COS_WIDTH-1:0] cos_vec;
`ifdef LDL_RR_PEND_CHK_EN
  logic [REQ_WIDTH-1:0]                bad_vec;
`endif

  assign take = bus.grant_valid & bus.grant_ready;

  genvar gi;
  generate
    for (gi = 0; gi < REQ_WIDTH; gi++) begin : g_req
      logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;
      logic [COS_WIDTH-1:0] base_reg, base_next;
      logic [COS_WIDTH-1:0] boost_reg, boost_next;
      logic [AGE_WIDTH-1:0] age_reg, age_next;
      logic                 is_full, is_req;
      logic                 acc, dec, lose;
      logic [COS_WIDTH:0]   cos_sum;

      assign is_full  = (cnt_reg == CNT_MAX);
      assign is_req   = (cnt_reg != '0);
      assign acc      = bus.push[gi] & ~is_full;
      assign dec      = take & bus.grant_hot[gi] & is_req;
      assign lose     = take & is_req & ~bus.grant_hot[gi];
      assign cnt_next = cnt_reg + CNT_WIDTH'(acc) - CNT_WIDTH'(dec);

      // Base cos: restart on a new burst, otherwise track the highest pushed cos.
      always_comb begin
        base_next = base_reg;
        if (cnt_next == '0) begin
          base_next = '0;
        end else if (acc) begin
          if ((cnt_reg == '0) || ((cnt_reg == CNT_ONE) && dec)) begin
            base_next = bus.push_cos[gi];
          end else if (bus.push_cos[gi] > base_reg) begin
            base_next = bus.push_cos[gi];
          end
        end
      end

      // Aging: count lost grants, bump the boost every AGE_LIMIT losses, clear on service.
      always_comb begin
        age_next   = age_reg;
        boost_next = boost_reg;
        if (dec || (cnt_next == '0)) begin
          age_next   = '0;
          boost_next = '0;
        end else if (lose) begin
          if (age_reg == AGE_TOP) begin
            age_next = '0;
            if (boost_reg != COS_MAX) begin
              boost_next = boost_reg + COS_ONE;
            end
          end else begin
            age_next = age_reg + AGE_ONE;
          end
        end
      end

      // Per-requester state registers.
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg   <= '0;
          base_reg  <= '0;
          boost_reg <= '0;
          age_reg   <= '0;
        end else begin
          cnt_reg   <= cnt_next;
          base_reg  <= base_next;
          boost_reg <= boost_next;
          age_reg   <= age_next;
        end
      end

      // One bit wider so the base+boost sum can be clamped instead of wrapping.
      assign cos_sum      = {1'b0, base_reg} + {1'b0, boost_reg};
      assign full_vec[gi] = is_full;
      assign req_vec[gi]  = is_req;
      assign cos_vec[gi]  = !is_req            ? '0 :
                            cos_sum[COS_WIDTH] ? COS_MAX :
                                                 cos_sum[COS_WIDTH-1:0];

`ifdef LDL_RR_PEND_CHK_EN
      assign bad_vec[gi] = (bus.push[gi] & is_full) |
                           (take & bus.grant_hot[gi] & ~is_req);
`endif
    end
  endgenerate

  assign bus.full = full_vec;
  assign bus.req  = req_vec;
  assign bus.cos  = cos_vec;

`ifdef LDL_RR_PEND_CHK_EN
  logic err_reg;
  logic hot_onehot;

  assign hot_onehot = (bus.grant_hot != '0) &&
                      ((bus.grant_hot & (bus.grant_hot - REQ_WIDTH'(1))) == '0);

  // Sticky protocol error: overflow push, malformed grant, or grant to an empty requester.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else if ((|bad_vec) || (take && !hot_onehot)) begin
      err_reg <= 1'b1;
    end
  end

  assign bus.err = err_reg;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_ldl_rr_pend_age.sv
// Table-driven bench for ldl_rr_pend_age (CNT_WIDTH=2, AGE_LIMIT=2 build).
// Expected records are queued when a vector is driven and popped after the edge.
module tb_ldl_rr_pend_age;

  typedef struct {
    string       name;
    bit          rst;
    logic [7:0]  push;
    logic [15:0] pcos;
    logic [7:0]  hot;
    bit          gv;
    bit          gr;
    logic [7:0]  e_req;
    logic [7:0]  e_full;
    logic [15:0] e_cos;
    bit          e_err;
  } vec_t;

`ifdef LDL_RR_PEND_CHK_EN
  localparam bit E = 1'b1;
`else
  localparam bit E = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  ldl_rr_pend_age_if #(.REQ_WIDTH(8), .COS_WIDTH(2)) bus ();

  ldl_rr_pend_age #(
    .BIN_WIDTH(3), .COS_WIDTH(2), .REQ_WIDTH(8),
    .CNT_WIDTH(2), .AGE_WIDTH(4), .AGE_LIMIT(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int   n_cmp  = 0;
  int   n_fail = 0;
  vec_t tbl[$];
  vec_t exp_q[$];

  function automatic logic [15:0] cv(input int i, input int v);
    logic [15:0] t;
    t  = 16'(v);
    cv = t << (2 * i);
  endfunction

  task automatic add(input string n, input bit r, input logic [7:0] p, input logic [15:0] pc,
                     input logic [7:0] h, input bit v, input bit rd,
                     input logic [7:0] eq, input logic [7:0] ef, input logic [15:0] ec,
                     input bit ee);
    vec_t t;
    t.name = n; t.rst = r; t.push = p; t.pcos = pc; t.hot = h; t.gv = v; t.gr = rd;
    t.e_req = eq; t.e_full = ef; t.e_cos = ec; t.e_err = ee;
    tbl.push_back(t);
  endtask

  task automatic chk(input string n, input string f, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s actual=%h required=%h", n, f, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    vec_t e;
    @(negedge clk);
    rst             = v.rst;
    bus.push        = v.push;
    bus.push_cos    = v.pcos;
    bus.grant_hot   = v.hot;
    bus.grant_valid = v.gv;
    bus.grant_ready = v.gr;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    $display("%-10s req=%h full=%h cos=%h err=%b", e.name, bus.req, bus.full, bus.cos, bus.err);
    chk(e.name, "req",  16'(bus.req),  16'(e.e_req));
    chk(e.name, "full", 16'(bus.full), 16'(e.e_full));
    chk(e.name, "cos",  16'(bus.cos),  e.e_cos);
    chk(e.name, "err",  16'(bus.err),  16'(e.e_err));
  endtask

  task automatic run_table();
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);
    tbl.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t s;
    bus.push = '0; bus.push_cos = '0; bus.grant_hot = '0;
    bus.grant_valid = 1'b0; bus.grant_ready = 1'b0;

    // name        rst push   pcos       hot    gv gr  req    full   cos        err
    add("rst0",    1, 8'hFF, 16'h0,     8'h00, 0, 0, 8'h00, 8'h00, 16'h0,     0);
    add("rst1",    1, 8'hFF, 16'h0,     8'h00, 0, 0, 8'h00, 8'h00, 16'h0,     0);
    add("idle",    0, 8'h00, 16'h0,     8'h00, 0, 0, 8'h00, 8'h00, 16'h0,     0);
    add("push2",   0, 8'h04, cv(2,2),   8'h00, 0, 0, 8'h04, 8'h00, cv(2,2),   0);
    add("grant2",  0, 8'h00, 16'h0,     8'h04, 1, 1, 8'h00, 8'h00, 16'h0,     0);
    add("fill0a",  0, 8'h01, 16'h0,     8'h00, 0, 0, 8'h01, 8'h00, 16'h0,     0);
    add("fill0b",  0, 8'h01, 16'h0,     8'h00, 0, 0, 8'h01, 8'h00, 16'h0,     0);
    add("fill0c",  0, 8'h01, 16'h0,     8'h00, 0, 0, 8'h01, 8'h01, 16'h0,     0);
    add("drop0",   0, 8'h01, 16'h0,     8'h00, 0, 0, 8'h01, 8'h01, 16'h0,     E);
    add("gnt0a",   0, 8'h00, 16'h0,     8'h01, 1, 1, 8'h01, 8'h00, 16'h0,     E);
    add("pg0",     0, 8'h01, 16'h0,     8'h01, 1, 1, 8'h01, 8'h00, 16'h0,     E);
    add("refill0", 0, 8'h01, 16'h0,     8'h00, 0, 0, 8'h01, 8'h01, 16'h0,     E);
    add("gnt0b",   0, 8'h00, 16'h0,     8'h01, 1, 1, 8'h01, 8'h00, 16'h0,     E);
    add("gnt0c",   0, 8'h00, 16'h0,     8'h01, 1, 1, 8'h01, 8'h00, 16'h0,     E);
    add("gnt0d",   0, 8'h00, 16'h0,     8'h01, 1, 1, 8'h00, 8'h00, 16'h0,     E);
    add("gnt_emp", 0, 8'h00, 16'h0,     8'h01, 1, 1, 8'h00, 8'h00, 16'h0,     E);
    add("rst2",    1, 8'h01, 16'h0,     8'h00, 0, 0, 8'h00, 8'h00, 16'h0,     0);
    add("age_set", 0, 8'h22, cv(5,3),   8'h00, 0, 0, 8'h22, 8'h00, 16'h0C00,  0);
    add("lose1",   0, 8'h20, cv(5,3),   8'h20, 1, 1, 8'h22, 8'h00, 16'h0C00,  0);
    add("lose2",   0, 8'h20, cv(5,3),   8'h20, 1, 1, 8'h22, 8'h00, 16'h0C04,  0);
    add("lose3",   0, 8'h20, cv(5,3),   8'h20, 1, 1, 8'h22, 8'h00, 16'h0C04,  0);
    run_table();

    // Stall: valid without ready must neither age nor boost requester 1.
    s.name = "stall"; s.rst = 0; s.push = 8'h00; s.pcos = 16'h0; s.hot = 8'h20;
    s.gv = 1; s.gr = 0; s.e_req = 8'h22; s.e_full = 8'h00; s.e_cos = 16'h0C04; s.e_err = 0;
    for (int k = 0; k < 20; k++) apply(s);

    add("lose4",   0, 8'h20, cv(5,3),   8'h20, 1, 1, 8'h22, 8'h00, 16'h0C08,  0);
    add("lose5",   0, 8'h20, cv(5,3),   8'h20, 1, 1, 8'h22, 8'h00, 16'h0C08,  0);
    add("lose6",   0, 8'h20, cv(5,3),   8'h20, 1, 1, 8'h22, 8'h00, 16'h0C0C,  0);
    add("lose7",   0, 8'h20, cv(5,3),   8'h20, 1, 1, 8'h22, 8'h00, 16'h0C0C,  0);
    add("lose8",   0, 8'h20, cv(5,3),   8'h20, 1, 1, 8'h22, 8'h00, 16'h0C0C,  0);
    add("g1push",  0, 8'h02, 16'h0,     8'h02, 1, 1, 8'h22, 8'h00, 16'h0C00,  0);
    add("g1",      0, 8'h00, 16'h0,     8'h02, 1, 1, 8'h20, 8'h00, 16'h0C00,  0);
    add("g5",      0, 8'h00, 16'h0,     8'h20, 1, 1, 8'h00, 8'h00, 16'h0,     0);
    add("base31",  0, 8'h08, cv(3,1),   8'h00, 0, 0, 8'h08, 8'h00, 16'h0040,  0);
    add("base33",  0, 8'h08, cv(3,3),   8'h00, 0, 0, 8'h08, 8'h00, 16'h00C0,  0);
    add("base30",  0, 8'h08, cv(3,0),   8'h00, 0, 0, 8'h08, 8'h08, 16'h00C0,  0);
    add("drain1",  0, 8'h00, 16'h0,     8'h08, 1, 1, 8'h08, 8'h00, 16'h00C0,  0);
    add("drain2",  0, 8'h00, 16'h0,     8'h08, 1, 1, 8'h08, 8'h00, 16'h00C0,  0);
    add("drain3",  0, 8'h00, 16'h0,     8'h08, 1, 1, 8'h00, 8'h00, 16'h0,     0);
    add("push30",  0, 8'h08, cv(3,0),   8'h00, 0, 0, 8'h08, 8'h00, 16'h0,     0);
    add("rst_mid", 1, 8'h00, 16'h0,     8'h00, 0, 0, 8'h00, 8'h00, 16'h0,     0);
    add("idle2",   0, 8'h00, 16'h0,     8'h00, 0, 0, 8'h00, 8'h00, 16'h0,     0);
    add("ge_push", 0, 8'h02, 16'h0,     8'h00, 0, 0, 8'h02, 8'h00, 16'h0,     0);
    add("ge1",     0, 8'h00, 16'h0,     8'h04, 1, 1, 8'h02, 8'h00, 16'h0,     E);
    add("ge2",     0, 8'h00, 16'h0,     8'h04, 1, 1, 8'h02, 8'h00, 16'h0004,  E);
    add("rst3",    1, 8'h00, 16'h0,     8'h00, 0, 0, 8'h00, 8'h00, 16'h0,     0);
    add("mh_push", 0, 8'h03, 16'h0,     8'h00, 0, 0, 8'h03, 8'h00, 16'h0,     0);
    add("mh_take", 0, 8'h00, 16'h0,     8'h03, 1, 1, 8'h00, 8'h00, 16'h0,     E);
    run_table();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
